// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous double-buffered data.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
    parameter int unsigned DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic [7:0]  en_mask_i,
    output logic        busy_o,
    output logic        frame_o,
    output logic [7:0]  AN,
    output logic [6:0]  hex
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(DIV - 1);

    cnt_t        div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] active_q, active_d;
    logic        busy_q, busy_d;
    logic        frame_q, frame_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  hex_q, hex_d;
    logic        tick, wrap;
    logic [3:0]  nib;
    logic [7:0]  lz;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = (div_q == CNT_MAX);
        wrap      = tick && (idx_q == 3'd7);
        div_d     = tick ? '0 : div_q + 1'b1;
        idx_d     = tick ? idx_q + 3'd1 : idx_q;
        pending_d = load_i ? data_i : pending_q;
        busy_d    = busy_q;
        active_d  = active_q;
        if (wrap) begin
            // A load landing exactly on the wrap bypasses the pending buffer.
            busy_d = 1'b0;
            if (load_i) begin
                active_d = data_i;
            end else if (busy_q) begin
                active_d = pending_q;
            end
        end else if (load_i) begin
            busy_d = 1'b1;
        end

        nib = active_d[{idx_d, 2'b00} +: 4];
        lz  = '0;
`ifdef SEG_LZB_EN
        for (int k = 1; k < 8; k++) begin
            lz[k] = ((active_d >> (4 * k)) == 32'd0);
        end
`endif

        // Outputs are computed from next state so the registered pins line up with div/idx.
        an_d = 8'hFF;
        if ((div_d != '0) && en_mask_i[idx_d] && !lz[idx_d]) begin
            an_d[idx_d] = 1'b0;
        end
        hex_d   = seg_decode(nib);
        frame_d = (div_d == CNT_MAX) && (idx_d == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= 3'd0;
            pending_q <= 32'd0;
            active_q  <= 32'd0;
            busy_q    <= 1'b0;
            frame_q   <= 1'b0;
            an_q      <= 8'hFF;
            hex_q     <= 7'h7F;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            frame_q   <= frame_d;
            an_q      <= an_d;
            hex_q     <= hex_d;
        end
    end

    assign busy_o  = busy_q;
    assign frame_o = frame_q;
    assign AN      = an_q;
    assign hex     = hex_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a timeline model predicts every output cycle.
module tb_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] hex;
        logic       frame;
        logic       busy;
    } exp_t;

    logic        clk;
    logic        rst_n = 1'b1;
    logic [31:0] data_i = '0;
    logic        load_i = 1'b0;
    logic [7:0]  en_mask_i = 8'hFF;
    logic        busy_o, frame_o;
    logic [7:0]  AN;
    logic [6:0]  hex;

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    string phase = "reset";
    exp_t  sb[$];

    // Model state: t counts cycles since reset release.
    int          t = 0;
    logic [31:0] m_active = '0;
    logic [31:0] m_pending = '0;
    logic        m_busy = 1'b0;

    seg_scan_ctrl #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i    (data_i),
        .load_i    (load_i),
        .en_mask_i (en_mask_i),
        .busy_o    (busy_o),
        .frame_o   (frame_o),
        .AN        (AN),
        .hex       (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t expect_at(int tt, logic [7:0] m, int c);
        exp_t e;
        int pos  = tt % DIV;
        int slot = (tt / DIV) % 8;
        logic [3:0] n = 4'(m_active >> (4 * slot));
        bit blank = LZB && (slot != 0) && ((m_active >> (4 * slot)) == 32'd0);
        e.cyc = c;
        e.an  = 8'hFF;
        if (pos != 0 && m[slot] && !blank) e.an[slot] = 1'b0;
        e.hex   = SEG[n];
        e.frame = (pos == DIV - 1) && (slot == 7);
        e.busy  = m_busy;
        return e;
    endfunction

    task automatic step(input logic l, input logic [31:0] d, input logic [7:0] m);
        load_i = l;
        data_i = d;
        en_mask_i = m;
        if ((t % FRAME) == FRAME - 1) begin
            if (l) m_active = d;
            else if (m_busy) m_active = m_pending;
            if (l) m_pending = d;
            m_busy = 1'b0;
        end else if (l) begin
            m_pending = d;
            m_busy = 1'b1;
        end
        t++;
        sb.push_back(expect_at(t, m, cyc + 1));
        @(posedge clk);
        #2;
    endtask

    task automatic idle_to(input int pos, input logic [7:0] m);
        while ((t % FRAME) != pos) step(1'b0, 32'd0, m);
    endtask

    task automatic run(input int n, input logic [7:0] m);
        repeat (n) step(1'b0, 32'd0, m);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        load_i = 1'b0;
        t = 0;
        m_active = '0;
        m_pending = '0;
        m_busy = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
            e.cyc = cyc; e.an = 8'hFF; e.hex = 7'h7F; e.frame = 1'b0; e.busy = 1'b0;
            sb.push_back(e);
        end
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            if (sb[0].cyc < cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL %s stale: expectation for cycle %0d unchecked at cycle %0d",
                         phase, e.cyc, cyc);
            end else if (sb[0].cyc == cyc) begin
                e = sb.pop_front();
                total++;
                if (AN !== e.an || hex !== e.hex || frame_o !== e.frame || busy_o !== e.busy) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got AN=%h hex=%h frame=%b busy=%b want AN=%h hex=%h frame=%b busy=%b",
                             phase, cyc, AN, hex, frame_o, busy_o, e.an, e.hex, e.frame, e.busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  mask;
        logic [31:0] d;
        #1;
        do_reset(3);

        phase = "scan_76543210";
        step(1'b1, 32'h7654_3210, 8'hFF);
        idle_to(0, 8'hFF);
        run(FRAME, 8'hFF);

        phase = "load_mid_frame";
        idle_to(3 * DIV + 1, 8'hFF);
        step(1'b1, 32'hFFFF_FFFF, 8'hFF);
        idle_to(0, 8'hFF);
        run(FRAME, 8'hFF);

        phase = "load_on_wrap";
        idle_to(FRAME - 1, 8'hFF);
        step(1'b1, 32'h1111_1111, 8'hFF);
        run(FRAME, 8'hFF);

        phase = "last_load_wins";
        step(1'b1, 32'h0123_4567, 8'hFF);
        step(1'b1, 32'h89AB_CDEF, 8'hFF);
        idle_to(0, 8'hFF);
        run(FRAME, 8'hFF);

        phase = "mask_0f";
        run(FRAME, 8'h0F);

        phase = "lzb_a05";
        step(1'b1, 32'h0000_0A05, 8'hFF);
        idle_to(0, 8'hFF);
        run(FRAME, 8'hFF);

        phase = "lzb_zero";
        step(1'b1, 32'h0000_0000, 8'hFF);
        idle_to(0, 8'hFF);
        run(FRAME, 8'hFF);

        phase = "random";
        mask = 8'hFF;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
            d = $urandom >> $urandom_range(0, 31);
            step($urandom_range(0, 7) == 0, d, mask);
        end

        phase = "reset_mid_frame";
        step(1'b1, 32'hDEAD_BEEF, 8'hFF);
        idle_to(13, 8'hFF);
        do_reset(2);
        step(1'b0, 32'd0, 8'hFF);
        run(2 * FRAME, 8'hFF);

        load_i = 1'b0;
        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
